// File: rtl/cu_pkg.sv
// Shared types and constants for the processor control unit:
// state encodings, opcodes, ALU selects and the opcode-to-state decoder.
package cu_pkg;

    localparam int PC_W_DEFAULT = 7;

    // State encodings are fixed because they are shown on State_out
    typedef enum logic [3:0] {
        ST_INIT   = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_NOOP   = 4'd3,
        ST_LOAD_A = 4'd4,
        ST_LOAD_B = 4'd5,
        ST_STORE  = 4'd6,
        ST_ADD    = 4'd7,
        ST_SUB    = 4'd8,
        ST_HALT   = 4'd9
    } state_t;

    typedef logic [3:0] opcode_t;

    localparam opcode_t OP_NOOP  = 4'b0000;
    localparam opcode_t OP_STORE = 4'b0001;
    localparam opcode_t OP_LOAD  = 4'b0010;
    localparam opcode_t OP_ADD   = 4'b0011;
    localparam opcode_t OP_SUB   = 4'b0100;
    localparam opcode_t OP_HALT  = 4'b0101;

    localparam logic [2:0] ALU_PASS = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;

    // First execute state for an opcode; unassigned opcodes run as NOOP
    function automatic state_t exec_state(input opcode_t op);
        state_t st;
        case (op)
            OP_STORE: st = ST_STORE;
            OP_LOAD:  st = ST_LOAD_A;
            OP_ADD:   st = ST_ADD;
            OP_SUB:   st = ST_SUB;
            OP_HALT:  st = ST_HALT;
            default:  st = ST_NOOP;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/control_unit_program_counter.sv
// Program counter: synchronous clear and increment, wrapping modulo 2^W.
module program_counter #(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clr,
    input  logic         up,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;

    // Reset/clear dominate; increment overflows naturally back to zero
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (up) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/control_unit.sv
// Processor control unit: fetches from a 1-cycle synchronous instruction ROM,
// holds IR, sequences FETCH/DECODE/EXECUTE and decodes datapath controls
// combinationally from state and IR.
module control_unit
    import cu_pkg::*;
#(
    parameter int PC_W = PC_W_DEFAULT
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [15:0]     I_data,
    output logic [PC_W-1:0] PC_Addr,
    output logic [7:0]      D_Addr,
    output logic            D_Wr,
    output logic            RF_s,
    output logic [3:0]      RF_W_Addr,
    output logic            RF_W_en,
    output logic [3:0]      RF_Ra_Addr,
    output logic [3:0]      RF_Rb_Addr,
    output logic [2:0]      ALU_s0,
    output logic [15:0]     IR_out,
    output logic [3:0]      State_out,
    output logic            Halted
);

    state_t      state_q;
    logic [15:0] ir_q;

    // Instruction fields
    logic [3:0] f_op;
    logic [3:0] f_hi;
    logic [3:0] f_mid;
    logic [3:0] f_lo;
    logic [7:0] f_addr;

    assign f_op   = ir_q[15:12];
    assign f_hi   = ir_q[11:8];
    assign f_mid  = ir_q[7:4];
    assign f_lo   = ir_q[3:0];
    assign f_addr = ir_q[7:0];

    // PC is parked at 0 in INIT and only advances while fetching
    logic pc_clr;
    logic pc_up;

    assign pc_clr = (state_q == ST_INIT);
    assign pc_up  = (state_q == ST_FETCH);

    program_counter #(
        .W(PC_W)
    ) u_pc (
        .clk    (clk),
        .reset_n(reset_n),
        .clr    (pc_clr),
        .up     (pc_up),
        .count  (PC_Addr)
    );

    // Sequencer: state transitions and IR capture during FETCH
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_INIT;
            ir_q    <= '0;
        end else begin
            case (state_q)
                ST_INIT:   state_q <= ST_FETCH;
                ST_FETCH: begin
                    ir_q    <= I_data;
                    state_q <= ST_DECODE;
                end
                ST_DECODE: state_q <= exec_state(f_op);
                ST_LOAD_A: state_q <= ST_LOAD_B;
                ST_NOOP,
                ST_LOAD_B,
                ST_STORE,
                ST_ADD,
                ST_SUB:    state_q <= ST_FETCH;
                ST_HALT:   state_q <= ST_HALT;
                default:   state_q <= ST_INIT;
            endcase
        end
    end

    // Moore decode of datapath controls; anything not driven for a state stays 0
    always_comb begin
        D_Addr     = '0;
        D_Wr       = 1'b0;
        RF_s       = 1'b0;
        RF_W_Addr  = '0;
        RF_W_en    = 1'b0;
        RF_Ra_Addr = '0;
        RF_Rb_Addr = '0;
        ALU_s0     = ALU_PASS;
        case (state_q)
            ST_STORE: begin
                D_Addr     = f_addr;
                RF_Ra_Addr = f_hi;
                D_Wr       = 1'b1;
            end
            ST_LOAD_A: begin
                // Address is presented one cycle early to cover memory read latency
                D_Addr = f_addr;
                RF_s   = 1'b1;
            end
            ST_LOAD_B: begin
                D_Addr    = f_addr;
                RF_s      = 1'b1;
                RF_W_Addr = f_hi;
                RF_W_en   = 1'b1;
            end
            ST_ADD: begin
                RF_Ra_Addr = f_hi;
                RF_Rb_Addr = f_mid;
                ALU_s0     = ALU_ADD;
                RF_W_Addr  = f_lo;
                RF_W_en    = 1'b1;
            end
            ST_SUB: begin
                RF_Ra_Addr = f_hi;
                RF_Rb_Addr = f_mid;
                ALU_s0     = ALU_SUB;
                RF_W_Addr  = f_lo;
                RF_W_en    = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign IR_out    = ir_q;
    assign State_out = state_q;
    assign Halted    = (state_q == ST_HALT);

endmodule
